peak_phase_extract: RTL and testbench
=====================================

// Module: peak_phase_extract
// PURPOSE
//  Receiving end of the FFT/magnitude result stream (valid/sop/eop, one beat per bin) in the PR3 chain.
//  Consumes three consecutive packets (antenna 0, 1, 2) and finds the peak-magnitude bin of antenna 0
//  inside a search window. Captures the phase of that same bin in all three packets and emits one
//  result beat: frequency, phaseA = ph1-ph0 and phaseB = ph2-ph0, each wrapped to [-pi,pi).
// PARAMETERS
//  FFT     11        log2 bins per packet; packet length N = 2**FFT beats
//  MWIDTH  25        magnitude width, UQ<MWIDTH>.0
//  FS_HZ   20000000  sample rate of time-domain data, Hz
//  BIN_LO  1         lowest bin searched (inclusive)
//  BIN_HI  1023      highest bin searched (inclusive), BIN_LO <= BIN_HI < N
// PORTS
//  clk           in   1       50 MHz processing clock; single clock domain
//  reset         in   1       asynchronous, active-high reset
//  sink_valid    in   1       input beat valid
//  sink_sop      in   1       first bin of packet (qualified by sink_valid)
//  sink_eop      in   1       last bin of packet (qualified by sink_valid)
//  sink_mag      in   MWIDTH  bin magnitude, UQ<MWIDTH>.0
//  sink_phase    in   16      bin phase, Q3.13 radians
//  source_valid  out  1       result beat valid, one-cycle pulse
//  source_sop    out  1       equals source_valid (single-beat packet)
//  source_eop    out  1       equals source_valid
//  source_freq   out  24      peak frequency in Hz, UQ24.0
//  source_phaseA out  16      ph1 - ph0 wrapped, Q3.13
//  source_phaseB out  16      ph2 - ph0 wrapped, Q3.13
//  source_error  out  1       malformed stream detected, one-cycle pulse
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE, internal registers cleared. Applies asynchronously, also mid-packet.
//  No backpressure: the block accepts every sink_valid beat. Beats with sink_valid=0 are ignored.
//  Bin counter: cleared on a valid sop beat, then increments on each valid beat.
//  FSM states: IDLE -> SCAN0 -> GAP1 -> SCAN1 -> GAP2 -> SCAN2 -> EMIT -> IDLE.
//   IDLE : wait for a valid sop beat -> SCAN0; valid non-sop beats are ignored.
//   SCAN0: for bin in [BIN_LO,BIN_HI], if mag > max (strict) store max, bin and ph0.
//          Ties keep the lowest bin. An all-zero window gives peak bin = BIN_LO with ph0 of BIN_LO.
//   SCAN1/SCAN2: when the bin counter equals the peak bin, capture ph1/ph2.
//   GAPn : wait for the next valid sop -> SCANn; valid non-sop beats -> error, IDLE.
//  Packet check: eop must arrive exactly on bin N-1, and no sop may appear inside a packet.
//   eop early or missing at N-1 -> source_error pulse, go to IDLE (result discarded).
//   sop mid-packet -> source_error pulse; that beat restarts as antenna 0 (-> SCAN0, bin 0).
//   A sop and eop on the same beat count as an early eop when N > 1.
//  Arithmetic, EMIT (2-stage pipeline):
//   d = ph_n - ph0 in 17 bits signed; if d >= 25736 then d -= 51472; if d < -25736 then d += 51472.
//   Result is truncated to 16 bits, where PI = 25736 (Q3.13).
//   freq = (peak_bin * FS_HZ) >> FFT; use a full-width product, truncate (floor) and saturate to 2^24-1.
//  Latency: source_valid (=sop=eop) is high exactly 2 cycles after the SCAN2 eop beat, for one cycle.
//   Data outputs hold their value until the next result. source_error is high 1 cycle after the offending beat.
//  A sop arriving during EMIT is accepted as a new SCAN0 start; EMIT output is not disturbed.
// TESTING
//  T1: peak at bin 100 (mag 5000, others 10); ph0=1000, ph1=3000, ph2=-1000
//      -> freq=976562, phaseA=2000, phaseB=-2000, valid 2 cycles after the last eop.
//  T2: wrap case, ph0=20000, ph1=-20000, ph2=20000 -> phaseA=11472, phaseB=0.
//  T3: equal max 7000 at bins 50 and 60, bin 0 = 99999 and bin 1500 = 99999 (outside window)
//      -> peak bin 50, freq=488281.
//  T4: eop at bin 100 of antenna-1 packet -> source_error pulse, no source_valid.
//      The next clean triplet produces a correct result.
//  T5: sop at bin 300 of SCAN2 -> error pulse; that packet plus 2 more give one valid result.
//  T6: reset asserted mid-SCAN1 for 1 cycle -> outputs 0 immediately, no result.
//      A following triplet matches T1.

Source files
------------

// File: rtl/peak_phase_extract_if.sv
// Stream bundle for peak_phase_extract: the FFT magnitude/phase sink
// stream coming in and the single-beat frequency/phase result going out.
interface peak_phase_extract_if #(
    parameter int MWIDTH = 25
);
    // Sink side: one beat per FFT bin, framed by sop/eop
    logic              sink_valid;
    logic              sink_sop;
    logic              sink_eop;
    logic [MWIDTH-1:0] sink_mag;
    logic [15:0]       sink_phase;

    // Source side: one result beat per antenna triplet, plus error pulse
    logic              source_valid;
    logic              source_sop;
    logic              source_eop;
    logic [23:0]       source_freq;
    logic [15:0]       source_phaseA;
    logic [15:0]       source_phaseB;
    logic              source_error;

    // Upstream producer / result consumer side
    modport master (
        output sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
        input  source_valid, source_sop, source_eop, source_freq,
               source_phaseA, source_phaseB, source_error
    );

    // The extractor itself
    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
        output source_valid, source_sop, source_eop, source_freq,
               source_phaseA, source_phaseB, source_error
    );
endinterface

// File: rtl/peak_phase_extract.sv
// Peak/phase extractor at the tail of the FFT magnitude chain.
// Takes three back-to-back packets (antenna 0, 1, 2), finds the strongest
// bin of antenna 0 inside [BIN_LO, BIN_HI], grabs the phase of that bin in
// all three packets and emits one beat with the peak frequency and the two
// wrapped phase differences relative to antenna 0.
module peak_phase_extract #(
    parameter int          FFT    = 11,
    parameter int          MWIDTH = 25,
    parameter int unsigned FS_HZ  = 20000000,
    parameter int          BIN_LO = 1,
    parameter int          BIN_HI = 1023
) (
    input logic                  clk,
    input logic                  reset,
    peak_phase_extract_if.slave  bus
);

    // Frequency product is bin (FFT bits) times a 32-bit sample rate
    localparam int              PW       = FFT + 32;
    localparam logic [FFT-1:0]  LAST_BIN = '1;
    localparam logic [FFT-1:0]  LO_BIN   = FFT'(BIN_LO);
    localparam logic [FFT-1:0]  HI_BIN   = FFT'(BIN_HI);

    typedef enum logic [2:0] {
        IDLE,
        SCAN0,
        GAP1,
        SCAN1,
        GAP2,
        SCAN2,
        EMIT
    } state_t;

    state_t             state_q;
    logic [FFT-1:0]     binCnt_q;
    logic [MWIDTH-1:0]  maxMag_q;
    logic [FFT-1:0]     peakBin_q;
    logic [15:0]        ph0_q;
    logic [15:0]        ph1_q;
    logic [15:0]        ph2_q;

    logic               srcValid_q;
    logic               srcError_q;
    logic [23:0]        srcFreq_q;
    logic [15:0]        srcPhaseA_q;
    logic [15:0]        srcPhaseB_q;

    logic [FFT-1:0]     curBin;
    logic               isLast;
    logic               eopBad;
    logic               beatActive;
    logic [1:0]         beatIdx;
    logic               structErr;
    logic               beatErr;
    state_t             beatNext;

    logic [PW-1:0]      freqProd;
    logic [PW-1:0]      freqScaled;
    logic [23:0]        freqSat;
    logic [15:0]        phaseA_d;
    logic [15:0]        phaseB_d;

    // Phase difference in 17 bits, folded back into [-pi, pi) with PI = 25736
    function automatic logic [15:0] wrapDiff(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] d;
        d = $signed({a[15], a}) - $signed({b[15], b});
        if (d >= 17'sd25736) begin
            d = d - 17'sd51472;
        end else if (d < -17'sd25736) begin
            d = d + 17'sd51472;
        end
        return d[15:0];
    endfunction

    // Classify the current beat: which antenna packet it belongs to (if any),
    // whether it breaks framing, and where the FSM goes after it. A sop always
    // restarts the bin count, so a misplaced sop is treated as bin 0 of a new
    // antenna-0 packet rather than dropped.
    always_comb begin
        curBin     = bus.sink_sop ? '0 : binCnt_q;
        isLast     = (curBin == LAST_BIN);
        eopBad     = (bus.sink_eop != isLast);
        beatActive = 1'b0;
        beatIdx    = 2'd0;
        structErr  = 1'b0;
        beatNext   = state_q;

        if (bus.sink_valid) begin
            unique case (state_q)
                IDLE, EMIT: begin
                    if (bus.sink_sop) begin
                        beatActive = 1'b1;
                        beatIdx    = 2'd0;
                    end
                end
                SCAN0: begin
                    beatActive = 1'b1;
                    beatIdx    = 2'd0;
                    structErr  = bus.sink_sop;
                end
                SCAN1, SCAN2: begin
                    beatActive = 1'b1;
                    structErr  = bus.sink_sop;
                    if (bus.sink_sop) begin
                        beatIdx = 2'd0;
                    end else begin
                        beatIdx = (state_q == SCAN1) ? 2'd1 : 2'd2;
                    end
                end
                GAP1, GAP2: begin
                    if (bus.sink_sop) begin
                        beatActive = 1'b1;
                        beatIdx    = (state_q == GAP1) ? 2'd1 : 2'd2;
                    end else begin
                        structErr  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        beatErr = structErr | (beatActive & eopBad);

        if (beatActive) begin
            if (eopBad) begin
                beatNext = IDLE;
            end else if (bus.sink_eop) begin
                unique case (beatIdx)
                    2'd0:    beatNext = GAP1;
                    2'd1:    beatNext = GAP2;
                    default: beatNext = EMIT;
                endcase
            end else begin
                unique case (beatIdx)
                    2'd0:    beatNext = SCAN0;
                    2'd1:    beatNext = SCAN1;
                    default: beatNext = SCAN2;
                endcase
            end
        end
    end

    // Second pipeline stage: scale the peak bin to Hz and wrap the phase
    // differences from the values captured during the three scans.
    always_comb begin
        freqProd   = PW'(peakBin_q) * PW'(FS_HZ);
        freqScaled = freqProd >> FFT;
        freqSat    = (|freqScaled[PW-1:24]) ? 24'hFFFFFF : freqScaled[23:0];
        phaseA_d   = wrapDiff(ph1_q, ph0_q);
        phaseB_d   = wrapDiff(ph2_q, ph0_q);
    end

    // Main FSM with the scan datapath and the registered result/error outputs.
    // The bin at BIN_LO is stored unconditionally so an all-zero window still
    // reports BIN_LO; later bins replace it only on a strictly larger magnitude.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            binCnt_q    <= '0;
            maxMag_q    <= '0;
            peakBin_q   <= '0;
            ph0_q       <= '0;
            ph1_q       <= '0;
            ph2_q       <= '0;
            srcValid_q  <= 1'b0;
            srcError_q  <= 1'b0;
            srcFreq_q   <= '0;
            srcPhaseA_q <= '0;
            srcPhaseB_q <= '0;
        end else begin
            srcValid_q <= 1'b0;
            srcError_q <= beatErr;

            if (bus.sink_valid) begin
                binCnt_q <= curBin + 1'b1;
            end

            if (state_q == EMIT) begin
                srcValid_q  <= 1'b1;
                srcFreq_q   <= freqSat;
                srcPhaseA_q <= phaseA_d;
                srcPhaseB_q <= phaseB_d;
            end

            if (beatActive) begin
                unique case (beatIdx)
                    2'd0: begin
                        if (curBin == LO_BIN) begin
                            maxMag_q  <= bus.sink_mag;
                            peakBin_q <= curBin;
                            ph0_q     <= bus.sink_phase;
                        end else if ((curBin > LO_BIN) && (curBin <= HI_BIN) &&
                                     (bus.sink_mag > maxMag_q)) begin
                            maxMag_q  <= bus.sink_mag;
                            peakBin_q <= curBin;
                            ph0_q     <= bus.sink_phase;
                        end
                    end
                    2'd1: begin
                        if (curBin == peakBin_q) begin
                            ph1_q <= bus.sink_phase;
                        end
                    end
                    default: begin
                        if (curBin == peakBin_q) begin
                            ph2_q <= bus.sink_phase;
                        end
                    end
                endcase
            end

            if (beatActive) begin
                state_q <= beatNext;
            end else if (beatErr) begin
                state_q <= IDLE;
            end else if (state_q == EMIT) begin
                state_q <= IDLE;
            end
        end
    end

    assign bus.source_valid  = srcValid_q;
    assign bus.source_sop    = srcValid_q;
    assign bus.source_eop    = srcValid_q;
    assign bus.source_freq   = srcFreq_q;
    assign bus.source_phaseA = srcPhaseA_q;
    assign bus.source_phaseB = srcPhaseB_q;
    assign bus.source_error  = srcError_q;

endmodule

// File: tb/tb_peak_phase_extract.sv
// Bench for peak_phase_extract: drives antenna triplets of full 2048-bin
// packets with sparse idle gaps, queues the expected result or error beat
// when the relevant input beat is driven, and compares on output.
module tb_peak_phase_extract;

    localparam int N = 2048;

    typedef struct {
        bit isErr;
        int cyc;
        int freq;
        int phA;
        int phB;
    } exp_t;

    logic clk;
    logic reset;
    int   cycleCnt = 0;
    int   totalChecks = 0;
    int   passChecks = 0;
    int   expFreq;
    int   expPhA;
    int   expPhB;

    logic [24:0] magArr [N];
    logic [15:0] phArr  [N];
    exp_t        expQ   [$];

    peak_phase_extract_if #(.MWIDTH(25)) bus ();

    peak_phase_extract #(
        .FFT    (11),
        .MWIDTH (25),
        .FS_HZ  (20000000),
        .BIN_LO (1),
        .BIN_HI (1023)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 50 MHz clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Edge counter used to time result and error beats
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input int obs, input int exp);
        totalChecks++;
        if (obs == exp) begin
            passChecks++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Pop the next expected event and compare it with what the DUT produced
    task automatic popCheck(input bit isErr);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput(isErr ? "unexpected error beat" : "unexpected result beat", 1, 0);
        end else begin
            e = expQ.pop_front();
            checkOutput("event kind", int'(isErr), int'(e.isErr));
            checkOutput("event cycle", cycleCnt, e.cyc);
            if (!isErr) begin
                checkOutput("freq", int'(bus.source_freq), e.freq);
                checkOutput("phaseA", int'($signed(bus.source_phaseA)), e.phA);
                checkOutput("phaseB", int'($signed(bus.source_phaseB)), e.phB);
                checkOutput("sop with valid", int'(bus.source_sop), 1);
                checkOutput("eop with valid", int'(bus.source_eop), 1);
            end
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.source_error) popCheck(1'b1);
            if (bus.source_valid) popCheck(1'b0);
        end
    end

    // Fill one packet: flat floor, one peak bin, a distinctive phase ramp
    task automatic fillPacket(input int pk, input int pkMag, input int base,
                              input int pkPh, input int seed);
        for (int i = 0; i < N; i++) begin
            magArr[i] = 25'(base);
            phArr[i]  = 16'(i * 37 + seed * 4099);
        end
        magArr[pk] = 25'(pkMag);
        phArr[pk]  = 16'(pkPh);
    endtask

    // Drive one packet of len beats from the arrays, with optional idle gaps;
    // queues an error on the first/last beat or a result on the last beat
    task automatic applyStimulus(input int len, input bit lastEop, input bit errFirst,
                                 input bit errLast, input bit resultLast);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 31) == 0) begin
                @(negedge clk);
                bus.sink_valid = 1'b0;
                bus.sink_sop   = 1'($urandom);
                bus.sink_eop   = 1'($urandom);
                bus.sink_mag   = 25'($urandom);
                bus.sink_phase = 16'($urandom);
            end
            @(negedge clk);
            bus.sink_valid = 1'b1;
            bus.sink_sop   = (i == 0);
            bus.sink_eop   = lastEop && (i == len - 1);
            bus.sink_mag   = magArr[i];
            bus.sink_phase = phArr[i];
            if ((i == 0 && errFirst) || (i == len - 1 && errLast)) begin
                e = '{isErr: 1'b1, cyc: cycleCnt + 1, freq: 0, phA: 0, phB: 0};
                expQ.push_back(e);
            end
            if (i == len - 1 && resultLast) begin
                e = '{isErr: 1'b0, cyc: cycleCnt + 2, freq: expFreq, phA: expPhA, phB: expPhB};
                expQ.push_back(e);
            end
            @(posedge clk);
            #1;
            bus.sink_valid = 1'b0;
        end
    endtask

    // Three clean packets with the same peak bin and the given phases
    task automatic runTriplet(input int pk, input int pkMag, input int base,
                              input int ph0, input int ph1, input int ph2,
                              input int eFreq, input int ePhA, input int ePhB,
                              input bit customAnt0, input bit errFirst);
        expFreq = eFreq;
        expPhA  = ePhA;
        expPhB  = ePhB;
        if (!customAnt0) fillPacket(pk, pkMag, base, ph0, 1);
        applyStimulus(N, 1'b1, errFirst, 1'b0, 1'b0);
        fillPacket(pk, pkMag, base, ph1, 2);
        applyStimulus(N, 1'b1, 1'b0, 1'b0, 1'b0);
        fillPacket(pk, pkMag, base, ph2, 3);
        applyStimulus(N, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset          = 1'b1;
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
        bus.sink_mag   = '0;
        bus.sink_phase = '0;
        repeat (3) @(negedge clk);

        checkOutput("reset valid", int'(bus.source_valid), 0);
        checkOutput("reset sop", int'(bus.source_sop), 0);
        checkOutput("reset eop", int'(bus.source_eop), 0);
        checkOutput("reset freq", int'(bus.source_freq), 0);
        checkOutput("reset phaseA", int'(bus.source_phaseA), 0);
        checkOutput("reset phaseB", int'(bus.source_phaseB), 0);
        checkOutput("reset error", int'(bus.source_error), 0);
        reset = 1'b0;

        $display("[TB] T1 basic peak");
        runTriplet(100, 5000, 10, 1000, 3000, -1000, 976562, 2000, -2000, 1'b0, 1'b0);

        $display("[TB] T2 phase wrap");
        runTriplet(300, 8000, 10, 20000, -20000, 20000, 2929687, 11472, 0, 1'b0, 1'b0);

        $display("[TB] T3 tie and out-of-window bins");
        fillPacket(50, 7000, 10, 1234, 1);
        magArr[60]   = 25'd7000;
        magArr[0]    = 25'd99999;
        magArr[1500] = 25'd99999;
        runTriplet(50, 7000, 10, 1234, 2234, 234, 488281, 1000, -1000, 1'b1, 1'b0);

        $display("[TB] T4 early eop in antenna 1");
        fillPacket(100, 5000, 10, 1000, 1);
        applyStimulus(N, 1'b1, 1'b0, 1'b0, 1'b0);
        fillPacket(100, 5000, 10, 3000, 2);
        applyStimulus(101, 1'b1, 1'b0, 1'b1, 1'b0);
        runTriplet(700, 3000, 20, 100, 200, 50, 6835937, 100, -50, 1'b0, 1'b0);

        $display("[TB] T5 sop inside antenna 2");
        fillPacket(400, 6000, 10, 111, 1);
        applyStimulus(N, 1'b1, 1'b0, 1'b0, 1'b0);
        fillPacket(400, 6000, 10, 222, 2);
        applyStimulus(N, 1'b1, 1'b0, 1'b0, 1'b0);
        fillPacket(400, 6000, 10, 333, 3);
        applyStimulus(300, 1'b0, 1'b0, 1'b0, 1'b0);
        runTriplet(200, 9000, 10, 0, -100, 100, 1953125, -100, 100, 1'b0, 1'b1);

        $display("[TB] T6 reset during antenna 1");
        fillPacket(100, 5000, 10, 1000, 1);
        applyStimulus(N, 1'b1, 1'b0, 1'b0, 1'b0);
        fillPacket(100, 5000, 10, 3000, 2);
        applyStimulus(500, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset valid", int'(bus.source_valid), 0);
        checkOutput("async reset freq", int'(bus.source_freq), 0);
        checkOutput("async reset phaseA", int'(bus.source_phaseA), 0);
        checkOutput("async reset phaseB", int'(bus.source_phaseB), 0);
        checkOutput("async reset error", int'(bus.source_error), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        runTriplet(100, 5000, 10, 1000, 3000, -1000, 976562, 2000, -2000, 1'b0, 1'b0);

        $display("[TB] T7 peak on BIN_HI");
        fillPacket(1023, 1000, 5, -30000, 1);
        magArr[1024] = 25'd60000;
        runTriplet(1023, 1000, 5, -30000, 30000, 5000, 9990234, 8528, -16472, 1'b1, 1'b0);

        $display("[TB] T8 all-zero window, wrap at +/-pi");
        fillPacket(1, 0, 0, 0, 1);
        magArr[0]    = 25'd500;
        magArr[2000] = 25'd500;
        runTriplet(1, 0, 0, 0, 25736, -25736, 9765, -25736, -25736, 1'b1, 1'b0);

        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
